// File: rtl/mips_cpu_bus_master.sv
// Bus master that turns single CPU load/store requests into a waitrequest-style
// bus transaction: lane placement, load extension, alignment and timeout checks.
module mips_cpu_bus_master #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;

  localparam logic [15:0] WAIT_MAX = 16'(WAIT_LIMIT);

  state_t      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic        is_signed_q, is_signed_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic [31:0] address_d, writedata_d, resp_rdata_d;
  logic [3:0]  byteenable_d;
  logic        read_d, write_d, resp_valid_d, resp_error_d;

  logic        accept, misaligned, wait_hit;
  logic [3:0]  req_be;
  logic [31:0] req_lanes, lane_mask, load_shifted, load_data;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign wait_hit  = (WAIT_MAX != 16'd0) && (wait_cnt_q + 16'd1 == WAIT_MAX);

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin : req_decode
    misaligned = 1'b0;
    req_be     = 4'b1111;
    case (req_size)
      2'b00:   req_be = 4'b0001 << req_addr[1:0];
      2'b01: begin
        req_be     = req_addr[1] ? 4'b1100 : 4'b0011;
        misaligned = req_addr[0];
      end
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
    lane_mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
    req_lanes = (req_wdata << {req_addr[1:0], 3'b000}) & lane_mask;
  end

  always_comb begin : load_extract
    load_shifted = readdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{is_signed_q & load_shifted[7]}},  load_shifted[7:0]};
      2'b01:   load_data = {{16{is_signed_q & load_shifted[15]}}, load_shifted[15:0]};
      default: load_data = readdata;
    endcase
  end

  // NOTE: blocking assignments here describe combinational next-state values;
  // only the always_ff below creates state, and it uses non-blocking assignments.
  always_comb begin : next_state
    state_d      = state_q;
    is_write_d   = is_write_q;
    is_signed_d  = is_signed_q;
    size_d       = size_q;
    lane_d       = lane_q;
    wait_cnt_d   = wait_cnt_q;
    address_d    = address;
    byteenable_d = byteenable;
    writedata_d  = writedata;
    read_d       = read;
    write_d      = write;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_write_d  = req_write;
          is_signed_d = req_signed;
          size_d      = req_size;
          lane_d      = req_addr[1:0];
          wait_cnt_d  = 16'd0;
          if (misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d      = ACCESS;
            address_d    = {req_addr[31:2], 2'b00};
            byteenable_d = req_be;
            writedata_d  = req_lanes;
            read_d       = !req_write;
            write_d      = req_write;
          end
        end
      end
      ACCESS: begin
        if (!waitrequest) begin
          read_d     = 1'b0;
          write_d    = 1'b0;
          wait_cnt_d = 16'd0;
          if (is_write_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = RDATA;
          end
        end else if (wait_hit) begin
          // Slave stalled too long: abandon the bus cycle and report it.
          read_d       = 1'b0;
          write_d      = 1'b0;
          wait_cnt_d   = 16'd0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      RDATA: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      is_signed_q <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      wait_cnt_q  <= 16'd0;
      address     <= 32'd0;
      byteenable  <= 4'd0;
      writedata   <= 32'd0;
      read        <= 1'b0;
      write       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_error  <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      is_signed_q <= is_signed_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      wait_cnt_q  <= wait_cnt_d;
      address     <= address_d;
      byteenable  <= byteenable_d;
      writedata   <= writedata_d;
      read        <= read_d;
      write       <= write_d;
      resp_valid  <= resp_valid_d;
      resp_rdata  <= resp_rdata_d;
      resp_error  <= resp_error_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Self-checking bench for mips_cpu_bus_master: random transactions scored every
// cycle against a transaction-level model of lanes, extension and latency.
module tb_mips_cpu_bus_master;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  mips_cpu_bus_master #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the current cycle, set by the stimulus thread.
  logic        chk_en = 1'b0;
  logic        e_ready, e_read, e_write, e_rv, e_err, e_bus, e_zero;
  logic [31:0] e_rdata, e_addr, e_wd;
  logic [3:0]  e_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic logic m_misaligned(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    if (size == 2'b11) return 1'b1;
    nb = 1 << size;
    return (addr % nb) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    logic [7:0] v;
    nb = 1 << size;
    v  = ((8'd1 << nb) - 8'd1) << addr[1:0];
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] addr,
                                       input logic [31:0] wdata);
    logic [63:0] sh;
    logic [31:0] r;
    logic [3:0]  be;
    sh = {32'd0, wdata} << (8 * addr[1:0]);
    be = m_be(size, addr);
    r  = 32'd0;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = sh[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] size, input logic sgn,
                                          input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v, mask;
    int bits;
    if (size == 2'b10) return rd;
    bits = 8 << size;
    v    = rd >> (8 * addr[1:0]);
    mask = (32'd1 << bits) - 32'd1;
    v    = v & mask;
    if (sgn && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic int m_latency(input logic w, input logic mis, input int stalls);
    if (mis) return 1;
    if (stalls >= WL) return WL + 1;
    return w ? stalls + 2 : stalls + 3;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("read", 32'(read), 32'(e_read));
      check("write", 32'(write), 32'(e_write));
      check("resp_valid", 32'(resp_valid), 32'(e_rv));
      check("resp_error", 32'(resp_error), 32'(e_err));
      check("resp_rdata", resp_rdata, e_rdata);
      if (e_bus) begin
        check("address", address, e_addr);
        check("byteenable", 32'(byteenable), 32'(e_be));
        if (e_write) check("writedata", writedata, e_wd);
      end
      if (e_zero) begin
        check("rst_address", address, 32'd0);
        check("rst_byteenable", 32'(byteenable), 32'd0);
        check("rst_writedata", writedata, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_exp(input logic ready);
    e_ready = ready; e_read = 1'b0; e_write = 1'b0; e_rv = 1'b0; e_err = 1'b0;
    e_bus = 1'b0; e_zero = 1'b0; e_rdata = 32'd0; e_addr = 32'd0; e_wd = 32'd0; e_be = 4'd0;
  endtask

  task automatic scramble_req();
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    req_valid   = 1'b0;
    scramble_req();
    waitrequest = 1'($urandom);
    readdata    = $urandom;
    clear_exp(1'b1);
    next_cycle();
  endtask

  task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int stalls);
    logic mis, tmo;
    int   acc, lat;
    mis = m_misaligned(sz, a);
    tmo = !mis && (stalls >= WL);
    acc = mis ? 0 : (tmo ? WL : stalls + 1);
    lat = m_latency(w, mis, stalls);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; readdata = rd; waitrequest = 1'($urandom);
    clear_exp(1'b1);
    next_cycle();
    req_valid = 1'b0;
    scramble_req();
    for (int n = 1; n <= lat; n++) begin
      clear_exp(1'b0);
      if (n <= acc) begin
        waitrequest = (n <= stalls);
        e_read  = !w;
        e_write = w;
        e_bus   = 1'b1;
        e_addr  = {a[31:2], 2'b00};
        e_be    = m_be(sz, a);
        e_wd    = m_wd(sz, a, wd);
      end else begin
        waitrequest = 1'($urandom);
      end
      if (n == lat) begin
        e_rv    = 1'b1;
        e_err   = mis || tmo;
        e_rdata = (mis || tmo || w) ? 32'd0 : m_rdata(sz, sg, a, rd);
      end
      next_cycle();
    end
  endtask

  // Word read stalled long enough to be in ACCESS, then reset for two cycles.
  task automatic reset_mid();
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_0030; waitrequest = 1'b1;
    clear_exp(1'b1);
    next_cycle();
    req_valid = 1'b0;
    clear_exp(1'b0);
    e_read = 1'b1; e_bus = 1'b1; e_addr = 32'h0000_0030; e_be = 4'hf;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    clear_exp(1'b0);
    e_zero = 1'b1;
    next_cycle();
    reset = 1'b0;
    clear_exp(1'b1);
    e_zero = 1'b1;
    next_cycle();
    repeat (4) idle_cycle();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; waitrequest = 1'b0; readdata = 32'd0;
    scramble_req();
    clear_exp(1'b0);

    // Model pins from hand-computed values.
    check("m_be_word_18", 32'(m_be(2'b10, 32'h18)), 32'hf);
    check("m_wd_word_18", m_wd(2'b10, 32'h18, 32'habcd12ff), 32'habcd12ff);
    check("m_be_byte_1b", 32'(m_be(2'b00, 32'h1b)), 32'h8);
    check("m_rd_sbyte_1b", m_rdata(2'b00, 1'b1, 32'h1b, 32'habcd12ff), 32'hffffffab);
    check("m_be_byte_19", 32'(m_be(2'b00, 32'h19)), 32'h2);
    check("m_rd_ubyte_19", m_rdata(2'b00, 1'b0, 32'h19, 32'habcd12ff), 32'h00000012);
    check("m_be_half_1a", 32'(m_be(2'b01, 32'h1a)), 32'hc);
    check("m_wd_half_1a", m_wd(2'b01, 32'h1a, 32'h0000ffff), 32'hffff0000);
    check("m_rd_uhalf_1a", m_rdata(2'b01, 1'b0, 32'h1a, 32'hffff0000), 32'h0000ffff);
    check("m_mis_word_1a", 32'(m_misaligned(2'b10, 32'h1a)), 32'd1);
    check("m_lat_write", m_latency(1'b1, 1'b0, 0), 2);
    check("m_lat_read_stall3", m_latency(1'b0, 1'b0, 3), 6);
    check("m_lat_error", m_latency(1'b0, 1'b1, 0), 1);
    check("m_lat_timeout", m_latency(1'b0, 1'b0, 9), WL + 1);

    next_cycle();
    next_cycle();
    // Reset held: state IDLE, everything zero, not ready.
    chk_en = 1'b1;
    clear_exp(1'b0);
    e_zero = 1'b1;
    next_cycle();
    reset = 1'b0;
    clear_exp(1'b1);
    e_zero = 1'b1;
    next_cycle();

    // Directed cases with the literal vectors.
    txn(1'b1, 2'b10, 1'b0, 32'h18, 32'habcd12ff, $urandom, 0);
    txn(1'b0, 2'b00, 1'b1, 32'h1b, $urandom, 32'habcd12ff, 0);
    txn(1'b0, 2'b00, 1'b0, 32'h19, $urandom, 32'habcd12ff, 0);
    txn(1'b1, 2'b01, 1'b0, 32'h1a, 32'h0000ffff, $urandom, 0);
    txn(1'b0, 2'b01, 1'b0, 32'h1a, $urandom, 32'hffff0000, 0);
    txn(1'b0, 2'b10, 1'b0, 32'h20, $urandom, 32'h12345678, 3);
    txn(1'b0, 2'b10, 1'b0, 32'h1a, $urandom, $urandom, 0);
    txn(1'b1, 2'b11, 1'b0, 32'h1c, $urandom, $urandom, 0);
    txn(1'b0, 2'b10, 1'b0, 32'h40, $urandom, $urandom, 9);
    txn(1'b1, 2'b00, 1'b0, 32'h43, 32'h000000a5, $urandom, WL - 1);
    idle_cycle();
    reset_mid();

    // Random traffic, including back-to-back requests.
    for (int i = 0; i < 300; i++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] a;
      int          stalls;
      repeat ($urandom_range(0, 2)) idle_cycle();
      w  = 1'($urandom);
      sg = 1'($urandom);
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      stalls = ($urandom_range(0, 7) == 0) ? $urandom_range(WL, WL + 3) : $urandom_range(0, 3);
      txn(w, sz, sg, a, $urandom, $urandom, stalls);
      if (i % 50 == 49) reset_mid();
    end

    idle_cycle();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_master.md
MIPS_CPU_BUS_MASTER -- requirements
Module: mips_cpu_bus_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter WAIT_LIMIT, default 0, SHALL be the maximum number of consecutive waitrequest=1 cycles tolerated in ACCESS; 0 SHALL mean unlimited.
REQ-003 The block SHALL provide these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  master can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word; 11 is illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_error  out  1  misaligned, illegal size, or timeout
- address  out  32  bus word address, {req_addr[31:2],2'b00}
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- byteenable  out  4  active byte lanes, little-endian
- writedata  out  32  lane-aligned store data
- waitrequest  in  1  slave stall
- readdata  in  32  full bus word

Function
REQ-004 The FSM SHALL have four states: IDLE, ACCESS, RDATA and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE with reset=0; a request SHALL be accepted on an edge where req_valid=1 and req_ready=1.
REQ-006 All request fields SHALL be latched on acceptance; later changes on the req_* inputs SHALL have no effect until the next acceptance.
REQ-007 A misaligned request SHALL go IDLE->RESP with no bus strobe and resp_error=1. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. size=11 SHALL be handled the same way.
REQ-008 An aligned request SHALL go IDLE->ACCESS. In ACCESS, address, byteenable, writedata and exactly one of read/write SHALL be driven from registers and held stable while waitrequest=1.
REQ-009 byteenable SHALL be:
- byte: 4'b0001<<addr[1:0]
- half: 4'b0011 when addr[1]=0, otherwise 4'b1100
- word: 4'b1111
REQ-010 writedata SHALL be req_wdata shifted left by 8*addr[1:0], masked to the enabled lanes, with all other lanes 0.
REQ-011 In ACCESS with waitrequest=0, a write SHALL go to RESP and a read SHALL go to RDATA; read and write SHALL drop to 0 on that same edge.
REQ-012 In RDATA, readdata SHALL be sampled and the enabled lanes extracted: shift right by 8*addr[1:0], then zero- or sign-extend from bit 7 (byte) or bit 15 (half). A word SHALL pass through unchanged. RDATA SHALL then go to RESP.
REQ-013 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE. resp_rdata and resp_error SHALL be valid only while resp_valid=1 and SHALL be 0 otherwise.
REQ-014 Latency from the acceptance edge to resp_valid SHALL be:
- write, no stall: 2 cycles
- read, no stall: 3 cycles
- error: 1 cycle
- each stall cycle: plus 1 cycle
REQ-015 With WAIT_LIMIT=N>0, a 16-bit counter SHALL count consecutive ACCESS cycles with waitrequest=1. When it reaches N, strobes SHALL drop, the FSM SHALL go to RESP with resp_error=1, and the counter SHALL clear.
REQ-016 Back-to-back requests SHALL be possible: a new request is accepted in the IDLE cycle that follows RESP.

Reset
REQ-017 While reset=1, the state SHALL be IDLE and the following SHALL all be 0: req_ready, resp_valid, resp_rdata, resp_error, read, write, byteenable, address, writedata and the wait counter.
REQ-018 Reset asserted mid-access SHALL abort the transaction: strobes SHALL be 0 from the following cycle, and no resp_valid SHALL be issued for the aborted request.

Verification
REQ-019 Store word 0xabcd12ff to 0x18 with waitrequest=0 -> address=0x18, byteenable=1111, writedata=0xabcd12ff; resp_valid 2 cycles after accept with resp_error=0.
REQ-020 Load byte signed from 0x1B with readdata=0xabcd12ff -> byteenable=1000, address=0x18, resp_rdata=0xffffffab. The same load unsigned from 0x19 -> byteenable=0010, resp_rdata=0x00000012.
REQ-021 Store half 0x0000ffff to 0x1A -> byteenable=1100, writedata=0xffff0000. Load half unsigned from 0x1A with readdata=0xffff0000 -> resp_rdata=0x0000ffff.
REQ-022 Read held off by 3 waitrequest cycles -> strobes and address stable across all 4 ACCESS cycles; resp_valid at accept+6 cycles.
REQ-023 Misaligned word load at 0x1A -> no read/write, resp_valid at accept+1 cycle with resp_error=1. With WAIT_LIMIT=4 and waitrequest stuck at 1 -> strobes drop after 4 cycles and resp_error=1.
REQ-024 Reset pulsed during ACCESS -> read=0 on the next cycle, no resp_valid, and req_ready=1 on the first cycle after reset deasserts.
